// File: rtl/ultrasonido_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ultrasonido_scheduler                                                      |
// | Round-robin shot sequencer for ultrasonic ranging controllers that share   |
// | one acoustic space: one shot at a time, timeout, quiet gap between shots.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ultrasonido_scheduler #(
    parameter int NUM_SENSORS    = 4,
    parameter int COUNT_W        = 8,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int GAP_CYCLES     = 3_000_000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable_i,
    input  logic [NUM_SENSORS-1:0]           mask_i,
    input  logic [NUM_SENSORS-1:0]           done_i,
    input  logic [NUM_SENSORS*COUNT_W-1:0]   count_i,
    input  logic [NUM_SENSORS-1:0]           detected_i,
    output logic [NUM_SENSORS-1:0]           ready_o,
    output logic [$clog2(NUM_SENSORS)-1:0]   sel_o,
    output logic                             busy_o,
    output logic                             result_valid_o,
    output logic [$clog2(NUM_SENSORS)-1:0]   result_id_o,
    output logic [COUNT_W-1:0]               result_count_o,
    output logic                             result_detected_o,
    output logic                             timeout_o,
    output logic [NUM_SENSORS-1:0]           detect_map_o,
    output logic                             frame_done_o
);

    localparam int IDX_W   = $clog2(NUM_SENSORS);
    localparam int TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]       TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]       GAP_LAST     = TMR_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]       LAST_IDX     = IDX_W'(NUM_SENSORS - 1);
    localparam logic [IDX_W:0]         NUM_EXT      = (IDX_W+1)'(NUM_SENSORS);
    localparam logic [NUM_SENSORS-1:0] ONE_HOT0     = NUM_SENSORS'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    state_t                   state_q;
    logic [IDX_W-1:0]         ptr_q;
    logic [IDX_W-1:0]         sel_q;
    logic [TMR_W-1:0]         timer_q;
    logic [NUM_SENSORS-1:0]   ready_q;
    logic                     res_valid_q;
    logic [IDX_W-1:0]         res_id_q;
    logic [COUNT_W-1:0]       res_count_q;
    logic                     res_det_q;
    logic                     timeout_q;
    logic [NUM_SENSORS-1:0]   detect_map_q;
    logic                     frame_done_q;

    logic [IDX_W-1:0]         sel_d;
    logic [IDX_W:0]           cand;
    logic                     done_sel;
    logic                     det_sel;
    logic [COUNT_W-1:0]       cnt_sel;
    logic [NUM_SENSORS-1:0]   above_sel;
    logic                     frame_last;

    // Scan downward so the smallest offset from ptr_q wins.
    always_comb begin
        sel_d = ptr_q;
        cand  = '0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand >= NUM_EXT) begin
                cand = cand - NUM_EXT;
            end
            if (mask_i[cand[IDX_W-1:0]]) begin
                sel_d = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        done_sel  = 1'b0;
        det_sel   = 1'b0;
        cnt_sel   = '0;
        above_sel = '0;
        for (int k = 0; k < NUM_SENSORS; k++) begin
            if (IDX_W'(k) == sel_q) begin
                done_sel = done_i[k];
                det_sel  = detected_i[k];
                cnt_sel  = count_i[k*COUNT_W +: COUNT_W];
            end
            if (IDX_W'(k) > sel_q) begin
                above_sel[k] = 1'b1;
            end
        end
    end

    assign frame_last = ~|(mask_i & above_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            sel_q        <= '0;
            timer_q      <= '0;
            ready_q      <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_count_q  <= '0;
            res_det_q    <= 1'b0;
            timeout_q    <= 1'b0;
            detect_map_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            ready_q      <= '0;
            res_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable_i && (|mask_i)) begin
                        state_q <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (|mask_i) begin
                        sel_q   <= sel_d;
                        ready_q <= ONE_HOT0 << sel_d;
                        state_q <= S_START;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_START: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    // A completion landing on the timeout cycle still counts as a good shot.
                    if (done_sel || (timer_q == TIMEOUT_LAST)) begin
                        res_valid_q         <= 1'b1;
                        res_id_q            <= sel_q;
                        res_count_q         <= done_sel ? cnt_sel : '0;
                        res_det_q           <= done_sel & det_sel;
                        timeout_q           <= ~done_sel;
                        detect_map_q[sel_q] <= done_sel & det_sel;
                        state_q             <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    timer_q <= '0;
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    timer_q <= timer_q + 1'b1;
                    if (timer_q == GAP_LAST) begin
                        ptr_q        <= (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
                        frame_done_q <= frame_last;
                        state_q      <= enable_i ? S_SELECT : S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o           = ready_q;
    assign sel_o             = sel_q;
    assign busy_o            = (state_q != S_IDLE);
    assign result_valid_o    = res_valid_q;
    assign result_id_o       = res_id_q;
    assign result_count_o    = res_count_q;
    assign result_detected_o = res_det_q;
    assign timeout_o         = timeout_q;
    assign detect_map_o      = detect_map_q;
    assign frame_done_o      = frame_done_q;

endmodule
`default_nettype wire
